// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer and a registered in_ready.
// Optional stall/bubble performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid_reg #(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       bubble_cnt
`endif
);

   // Handshake: a transfer happens on a rising edge where valid and ready are both high.
   // Upstream may change in_valid/in_data freely while in_ready is low; they are ignored.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_n;
   logic [DATA_W-1:0] main_d;
   logic [DATA_W-1:0] main_d_n;
   logic [DATA_W-1:0] skid_d;
   logic [DATA_W-1:0] skid_d_n;
   logic              ready_q;
   logic              ready_n;
   logic              main_v;
   logic              skid_v;
   logic              accept;
   logic              emit;

   assign main_v    = (state != ST_EMPTY);
   assign skid_v    = (state == ST_FULL);
   assign accept    = in_valid & ready_q;
   assign emit      = main_v & out_ready;
   assign in_ready  = ready_q;
   assign out_valid = main_v;
   assign out_data  = main_v ? main_d : RESET_VAL;
   assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_EMPTY;
         main_d  <= RESET_VAL;
         skid_d  <= RESET_VAL;
         ready_q <= 1'b1;
      end else begin
         state   <= state_n;
         main_d  <= main_d_n;
         skid_d  <= skid_d_n;
         ready_q <= ready_n;
      end
   end

   always_comb begin
      state_n  = state;
      main_d_n = main_d;
      skid_d_n = skid_d;
      if (flush) begin
         // An accept in this cycle is dropped; upstream still treats it as consumed.
         state_n  = ST_EMPTY;
         main_d_n = RESET_VAL;
         skid_d_n = RESET_VAL;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_n  = ST_ONE;
                  main_d_n = in_data;
               end
            end
            ST_ONE: begin
               case ({accept, emit})
                  2'b11: main_d_n = in_data;
                  2'b10: begin
                     state_n  = ST_FULL;
                     skid_d_n = in_data;
                  end
                  2'b01: begin
                     state_n  = ST_EMPTY;
                     main_d_n = RESET_VAL;
                  end
                  default: ;
               endcase
            end
            ST_FULL: begin
               // ready_q is low here, so no accept can coincide with the skid drain.
               if (emit) begin
                  state_n  = ST_ONE;
                  main_d_n = skid_d;
                  skid_d_n = RESET_VAL;
               end
            end
            default: begin
               state_n  = ST_EMPTY;
               main_d_n = RESET_VAL;
               skid_d_n = RESET_VAL;
            end
         endcase
      end
      ready_n = (state_n != ST_FULL);
   end

`ifdef PIPE_STAGE_PERF_EN
   // Classified from the current out_valid, so a flush cycle counts by its pre-flush contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (main_v && !out_ready && (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
         if (!main_v && out_ready && (bubble_cnt != 32'hFFFF_FFFF))
            bubble_cnt <= bubble_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Scoreboard bench for pipe_stage_skid_reg: a reference queue tracks held entries and expected outputs.
module tb_pipe_stage_skid_reg;

   localparam int unsigned       DATA_W    = 32;
   localparam logic [DATA_W-1:0] RESET_VAL = '0;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       bubble_cnt;
   logic [31:0]       m_stall = '0;
   logic [31:0]       m_bubble = '0;
`endif

   int checks   = 0;
   int failures = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic              mon_en   = 1'b0;
   logic              watch_77 = 1'b0;
   logic              seen_77  = 1'b0;

   pipe_stage_skid_reg #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // driver tasks
   task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic r, input logic f);
      in_valid  = v;
      in_data   = d;
      out_ready = r;
      flush     = f;
   endtask

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // scoreboard: compare the state left by the last edge, then model the coming edge
   always @(negedge clk) begin
      if (mon_en) begin
         int sz;
         logic [DATA_W-1:0] exp_d;
         sz = exp_q.size();
         check_eq("out_valid", out_valid, sz != 0);
         check_eq("in_ready", in_ready, sz < 2);
         check_eq("occupancy", occupancy, sz);
         if (sz == 0) check_eq("out_data_empty", out_data, RESET_VAL);
`ifdef PIPE_STAGE_PERF_EN
         check_eq("stall_cnt", stall_cnt, m_stall);
         check_eq("bubble_cnt", bubble_cnt, m_bubble);
         if (reset) begin
            m_stall  = '0;
            m_bubble = '0;
         end else begin
            if (sz != 0 && !out_ready && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
            if (sz == 0 && out_ready && m_bubble != 32'hFFFF_FFFF) m_bubble = m_bubble + 1;
         end
`endif
         if (!reset && out_ready && sz != 0) begin
            exp_d = exp_q.pop_front();
            check_eq("out_data", out_data, exp_d);
            if (watch_77 && out_data == 32'h77) seen_77 = 1'b1;
         end
         if (reset || flush) exp_q.delete();
         else if (in_valid && sz < 2) exp_q.push_back(in_data);
      end
   end

   initial begin
      // reset with junk presented
      reset = 1'b1;
      drive(1'b1, 32'hA5, 1'b0, 1'b0);
      @(posedge clk);
      mon_en = 1'b1;
      #1;
      step(1);
      reset = 1'b0;

      // full-throughput stream
      drive(1'b1, 32'h1, 1'b1, 1'b0); step(1);
      drive(1'b1, 32'h2, 1'b1, 1'b0); step(1);
      drive(1'b1, 32'h3, 1'b1, 1'b0); step(1);
      drive(1'b0, 32'h0, 1'b1, 1'b0); step(2);

      // skid fill, held input ignored, ordered drain
      drive(1'b1, 32'h10, 1'b0, 1'b0); step(1);
      drive(1'b1, 32'h20, 1'b0, 1'b0); step(1);
      drive(1'b1, 32'h30, 1'b0, 1'b0); step(3);
      drive(1'b1, 32'h30, 1'b1, 1'b0); step(2);
      drive(1'b0, 32'h0, 1'b1, 1'b0); step(3);

      // flush while full, with an accept-looking input in the flush cycle
      drive(1'b1, 32'h40, 1'b0, 1'b0); step(1);
      drive(1'b1, 32'h50, 1'b0, 1'b0); step(1);
      watch_77 = 1'b1;
      drive(1'b1, 32'h77, 1'b0, 1'b1); step(1);
      drive(1'b0, 32'h0, 1'b1, 1'b0); step(3);
      watch_77 = 1'b0;
      check_eq("no_77", seen_77, 1'b0);

      // reset while stalled and full
      drive(1'b1, 32'h60, 1'b0, 1'b0); step(1);
      drive(1'b1, 32'h61, 1'b0, 1'b0); step(1);
      reset = 1'b1; step(1);
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b1, 1'b0); step(2);

`ifdef PIPE_STAGE_PERF_EN
      reset = 1'b1; step(1);
      reset = 1'b0;
      drive(1'b1, 32'h5, 1'b0, 1'b0); step(1);
      drive(1'b0, 32'h0, 1'b0, 1'b0); step(4);
      drive(1'b0, 32'h0, 1'b1, 1'b0); step(1);
      step(3);
      check_eq("perf_stall4", stall_cnt, 32'd4);
      check_eq("perf_bubble3", bubble_cnt, 32'd3);
      force dut.stall_cnt = 32'hFFFF_FFFF;
      m_stall = 32'hFFFF_FFFF;
      drive(1'b1, 32'h6, 1'b0, 1'b0); step(1);
      release dut.stall_cnt;
      drive(1'b0, 32'h0, 1'b0, 1'b0); step(3);
      check_eq("perf_stall_sat", stall_cnt, 32'hFFFF_FFFF);
      drive(1'b0, 32'h0, 1'b1, 1'b0); step(2);
`endif

      // random traffic with occasional flushes
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 3) != 0,
               $urandom_range(0, 31) == 0);
         step(1);
      end

      drive(1'b0, 32'h0, 1'b1, 1'b0); step(4);
      check_eq("drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
- Generic parametrised inter-stage pipeline register for the pipelined MIPS core (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Replaces the fixed-field, stall-as-bubble stage registers with a valid/ready handshake and a 2-entry skid buffer.
- In the skid buffer, in_ready is fully registered, so back-pressure does not form a combinational path across stages.
- A separate flush input inserts bubbles on branch/jump redirect, independent of stall.

Parameters:
- DATA_W, 32, width of the packed stage payload (op_type, PC, operands, imm, reg addrs, ...).
- RESET_VAL, 0, value driven on out_data after reset/flush and while the stage is empty; width DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream stage presents a valid instruction.
- in_ready  output  1  this stage can accept; registered output.
- in_data  input  DATA_W  upstream payload.
- flush  input  1  synchronous kill of all held entries; highest priority after reset.
- out_valid  output  1  downstream payload valid.
- out_ready  input  1  downstream stage accepts (low = stall from hazard unit).
- out_data  output  DATA_W  payload to downstream; equals main entry.
- occupancy  output  2  number of held entries, 0..2.

Behaviour:
- Storage:
  - main entry: main_v, main_d. Drives out_valid/out_data.
  - skid entry: skid_v, skid_d.
  - in_ready = ~skid_v, from a flop.
  - occupancy = main_v + skid_v.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Emit when out_valid & out_ready.
  - in_data/in_valid may change freely while in_ready=0; they are ignored.
- Reset (sync, active-high), all at the next edge:
  - main_v=0, skid_v=0.
  - main_d=skid_d=RESET_VAL.
  - in_ready=1, out_valid=0, out_data=RESET_VAL, occupancy=0.
- Flush (evaluated when reset=0):
  - Same end state as reset.
  - An accept in the flush cycle is discarded; upstream considers it consumed.
  - An emit in the flush cycle still counts for downstream.
- Normal update, per cycle (no reset, no flush). States are EMPTY (0), ONE (main only) and FULL (main+skid):
  - EMPTY, accept -> ONE; main_d=in_data. Latency in->out is 1 cycle.
  - ONE, accept & emit -> ONE; main_d=in_data (full throughput).
  - ONE, accept & ~emit -> FULL; skid_d=in_data; in_ready falls next cycle.
  - ONE, ~accept & emit -> EMPTY; main_d=RESET_VAL.
  - ONE, ~accept & ~emit -> ONE; hold.
  - FULL, emit -> ONE; main_d=skid_d, skid_d=RESET_VAL; in_ready rises next cycle. No accept is possible in FULL.
  - FULL, ~emit -> FULL; hold.
- Ordering: strictly FIFO. skid_d is never emitted ahead of main_d.
- Empty: out_data is forced to RESET_VAL whenever main_v=0, so downstream decode sees a NOP.
- Invariants:
  - skid_v=1 implies main_v=1.
  - No payload is duplicated or lost except by flush/reset.
- Reset/flush mid-stall: the held entries are dropped; no partial state survives.

Optional Feature:
- Macro PIPE_STAGE_PERF_EN.
- When defined, two extra output ports are added:
  - stall_cnt [31:0]: counts cycles with out_valid & ~out_ready.
  - bubble_cnt [31:0]: counts cycles with ~out_valid & out_ready.
- Counter rules:
  - Both saturate at 0xFFFFFFFF.
  - Both clear on reset only; flush does not clear them.
  - The flush cycle itself is classified from pre-flush out_valid.
- When undefined, the ports and logic are absent; the datapath is identical.

Test Plan:
- Reset: reset=1 for 2 cycles with in_valid=1, in_data=0xA5 -> out_valid=0, out_data=0x0, in_ready=1, occupancy=0 after the first edge.
- Throughput: out_ready=1, stream 0x1,0x2,0x3 on consecutive cycles -> out_data 0x1,0x2,0x3 on the following consecutive cycles; in_ready stays 1; occupancy=1.
- Skid: load 0x10; out_ready=0 and present 0x20 -> occupancy=2, in_ready=0 next cycle; hold 3 cycles with 0x30 presented (ignored); out_ready=1 -> emits 0x10 then 0x20, then 0x30 is accepted once in_ready=1.
- Flush while FULL, with in_valid=1, in_data=0x77 -> next cycle out_valid=0, occupancy=0, in_ready=1, out_data=RESET_VAL; 0x77 never appears.
- Reset during stall (occupancy=2) -> all outputs return to reset values within 1 cycle.
- Perf (PIPE_STAGE_PERF_EN): 4 cycles of out_valid=1 with out_ready=0, then 3 empty cycles with out_ready=1 -> stall_cnt=4, bubble_cnt=3. A counter preloaded to 0xFFFFFFFF (via force) stays at 0xFFFFFFFF after further counting cycles.
